// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage that waits for DCache data, aligns load results and forwards the instruction to WB.
// Ports: clk/reset (async active-low), es_to_ms_valid/es_to_ms_bus in from EXE, ms_allowin back to EXE,
// ms_to_ws_valid/ms_to_ws_bus out to WB with ws_allowin back, data_data_ok/data_rdata from DCache,
// flush discards the held instruction, MEM_dest/MEM_result/ms_res_valid/ms_ex/ms_inst_eret/ms_inst_mfc0 to hazard logic.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 165,
    parameter int MS_TO_WS_BUS_WD = 120
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_data_ok,
    input  logic [31:0]                data_rdata,
    input  logic                       flush,
    output logic [4:0]                 MEM_dest,
    output logic [31:0]                MEM_result,
    output logic                       ms_res_valid,
    output logic                       ms_ex,
    output logic                       ms_inst_eret,
    output logic                       ms_inst_mfc0
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, DISCARD} state_t;
    state_t                     r_state;
    logic                       r_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] r_bus;
    logic [31:0]                r_rdata_buf;
    logic [31:0] w_addr, w_rt, w_alu, w_pc, w_rd, w_lwl, w_lwr, w_load_data, w_final;
    logic [11:0] w_mi;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [1:0]  w_b;
    logic w_load, w_gr_we, w_ex, w_need_mem, w_ready_go, w_accept, w_depart, w_unused;
    assign w_addr = r_bus[164:133];
    assign w_ex   = r_bus[127];
    assign w_rt   = r_bus[114:83];
    assign w_mi   = r_bus[82:71];
    assign w_load = r_bus[70];
    assign w_gr_we = r_bus[69];
    assign w_alu  = r_bus[63:32];
    assign w_pc   = r_bus[31:0];
    // store-type bits only matter on the incoming bus (need_mem), not once held
    assign w_unused = &{1'b0, w_mi[11:8], w_mi[1:0]};
    // loads and all store variants go to the DCache unless the instruction already faulted
    assign w_need_mem = (es_to_ms_bus[70] | es_to_ms_bus[72] | (|es_to_ms_bus[82:79])) & ~es_to_ms_bus[127];
    assign w_ready_go = (r_state == IDLE) | (r_state == DONE) | (r_state == WAIT & data_data_ok);
    assign ms_to_ws_valid = r_ms_valid & w_ready_go;
    assign ms_allowin = (r_state != DISCARD) & (~r_ms_valid | (w_ready_go & ws_allowin));
    assign w_accept = es_to_ms_valid & ms_allowin & ~flush;
    assign w_depart = ms_to_ws_valid & ws_allowin;
    // zero-cycle bypass: use the live DCache data while waiting, buffered data once parked in DONE
    assign w_rd = (r_state == DONE) ? r_rdata_buf : data_rdata;
    assign w_b  = w_addr[1:0];
    assign w_byte = (w_b == 2'd0) ? w_rd[7:0] : (w_b == 2'd1) ? w_rd[15:8] : (w_b == 2'd2) ? w_rd[23:16] : w_rd[31:24];
    assign w_half = w_b[1] ? w_rd[31:16] : w_rd[15:0];
    assign w_lwl = (w_b == 2'd0) ? {w_rd[7:0], w_rt[23:0]} : (w_b == 2'd1) ? {w_rd[15:0], w_rt[15:0]} :
                   (w_b == 2'd2) ? {w_rd[23:0], w_rt[7:0]} : w_rd;
    assign w_lwr = (w_b == 2'd0) ? w_rd : (w_b == 2'd1) ? {w_rt[31:24], w_rd[31:8]} :
                   (w_b == 2'd2) ? {w_rt[31:16], w_rd[31:16]} : {w_rt[31:8], w_rd[31:24]};
    assign w_load_data = w_mi[2] ? {{24{w_byte[7]}}, w_byte} : w_mi[3] ? {24'b0, w_byte} :
                         w_mi[4] ? {{16{w_half[15]}}, w_half} : w_mi[5] ? {16'b0, w_half} :
                         w_mi[6] ? w_lwl : w_mi[7] ? w_lwr : w_rd;
    assign w_final = w_load ? w_load_data : w_alu;
    assign ms_to_ws_bus = {r_bus[132:115], w_addr, w_gr_we, r_bus[68:64], w_final, w_pc};
    assign MEM_dest     = (r_ms_valid & w_gr_we) ? r_bus[68:64] : 5'd0;
    assign MEM_result   = w_final;
    assign ms_res_valid = r_ms_valid & (~w_load | w_ready_go);
    assign ms_ex        = r_ms_valid & w_ex;
    assign ms_inst_eret = r_ms_valid & r_bus[120];
    assign ms_inst_mfc0 = r_ms_valid & r_bus[115];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ms_valid  <= 1'b0;
            r_bus       <= '0;
            r_rdata_buf <= '0;
        end else if (flush) begin
            r_ms_valid <= 1'b0;
            // an access still in flight must have its response swallowed later
            if (r_state == WAIT)
                r_state <= data_data_ok ? IDLE : DISCARD;
            else if (r_state == DONE || (r_state == DISCARD && data_data_ok))
                r_state <= IDLE;
        end else if (w_accept) begin
            r_bus      <= es_to_ms_bus;
            r_ms_valid <= 1'b1;
            r_state    <= w_need_mem ? WAIT : IDLE;
        end else if (w_depart) begin
            r_ms_valid <= 1'b0;
            r_state    <= IDLE;
        end else if (r_state == WAIT && data_data_ok) begin
            r_rdata_buf <= data_rdata;
            r_state     <= DONE;
        end else if (r_state == DISCARD && data_data_ok) begin
            r_state <= IDLE;
        end
    end
endmodule
